// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between the core control path (master) and mem_responder (slave)
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: RV32I unified memory with LED/ms-timer MMIO; defining MEM_RESPONDER_WAIT_EN adds WAIT_CYCLES response delay
module mem_responder #(
  parameter int          DEPTH_WORDS = 2048,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] LED_ADDR    = 32'hFFFF_FFFC,
  parameter logic [31:0] TIMER_ADDR  = 32'hFFFF_FFF8,
  parameter int          CLK_PER_MS  = 12000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_responder_if.slave bus,
  output logic [7:0]    leds,
  output logic [31:0]   ms_count
);
`ifdef MEM_RESPONDER_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam int WC = WAIT_EN ? WAIT_CYCLES : 0;
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [AW-1:0] r_idx;
  logic [1:0] r_lane;
  logic [2:0] r_f3;
  logic [31:0] r_rdata, r_pre, r_ms, r_wcnt;
  logic [7:0] r_leds;
  logic r_err;
  logic w_acc, w_led, w_tmr, w_mmio, w_f3_ok, w_al, w_err, w_rd_mem, w_wr_mem, w_wr_led, w_wr_tmr;
  logic [3:0] w_be;
  logic [31:0] w_wd, w_word, w_ld;
  logic [7:0] w_b;
  logic [15:0] w_h;
  assign bus.req_ready = rst_n && r_state == IDLE;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err && r_state == RESP;
  assign leds          = r_leds;
  assign ms_count      = r_ms;
  assign w_acc   = bus.req_valid && bus.req_ready;
  assign w_led   = bus.req_addr == LED_ADDR;
  assign w_tmr   = bus.req_addr == TIMER_ADDR;
  assign w_mmio  = w_led || w_tmr;
  assign w_f3_ok = bus.req_we ? bus.req_funct3 <= 3'd2 : !(bus.req_funct3[1:0] == 2'b11 || bus.req_funct3 == 3'b110);
  assign w_al    = bus.req_funct3[1:0] == 2'b00 ||
                   (bus.req_funct3[1:0] == 2'b01 && !bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] == 2'b00);
  assign w_err    = !w_f3_ok || !w_al ||
                    (w_mmio ? bus.req_we && bus.req_funct3 != 3'b010 : bus.req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_rd_mem = !w_err && !w_mmio && !bus.req_we;
  assign w_wr_mem = w_acc && !w_err && !w_mmio && bus.req_we;
  assign w_wr_led = w_acc && !w_err && w_led && bus.req_we;
  assign w_wr_tmr = w_acc && !w_err && w_tmr && bus.req_we;
  assign w_be = bus.req_funct3[1] ? 4'hF : bus.req_funct3[0] ? 4'h3 << {bus.req_addr[1], 1'b0} : 4'h1 << bus.req_addr[1:0];
  assign w_wd = bus.req_funct3[1] ? bus.req_wdata : bus.req_funct3[0] ? {2{bus.req_wdata[15:0]}} : {4{bus.req_wdata[7:0]}};
  assign w_word = r_mem[r_idx];
  assign w_b    = 8'(w_word >> {r_lane, 3'b000});
  assign w_h    = 16'(w_word >> {r_lane[1], 4'b0000});
  assign w_ld   = r_f3[1] ? w_word : r_f3[0] ? {{16{~r_f3[2] & w_h[15]}}, w_h} : {{24{~r_f3[2] & w_b[7]}}, w_b};
  always_ff @(posedge clk)
    if (w_wr_mem)
      for (int i = 0; i < 4; i++)
        if (w_be[i]) r_mem[bus.req_addr[AW+1:2]][8*i +: 8] <= w_wd[8*i +: 8];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_acc ? IDLE : w_rd_mem ? RD_WAIT : WC != 0 ? WAIT : RESP;
      RD_WAIT: w_next = WC != 0 ? WAIT : RESP;
      WAIT:    w_next = r_wcnt == 32'(WC - 1) ? RESP : WAIT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_lane  <= '0;
      r_f3    <= '0;
      r_wcnt  <= '0;
    end else begin
      r_wcnt <= r_state == WAIT ? r_wcnt + 32'd1 : '0;
      if (w_acc) begin
        r_idx   <= bus.req_addr[AW+1:2];
        r_lane  <= bus.req_addr[1:0];
        r_f3    <= bus.req_funct3;
        r_err   <= w_err;
        r_rdata <= w_err || bus.req_we ? '0 : w_led ? {24'h0, r_leds} : w_tmr ? r_ms : '0;
      end else if (r_state == RD_WAIT) r_rdata <= w_ld;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_leds <= '0;
      r_pre  <= '0;
      r_ms   <= '0;
    end else begin
      if (w_wr_led) r_leds <= bus.req_wdata[7:0];
      if (w_wr_tmr) begin
        r_pre <= '0;
        r_ms  <= '0;
      end else if (r_pre == 32'(CLK_PER_MS - 1)) begin
        r_pre <= '0;
        r_ms  <= r_ms + 32'd1;
      end else r_pre <= r_pre + 32'd1;
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against a byte-array reference model
module tb_mem_responder;
  localparam int DW  = 64;
  localparam int CPM = 4;
  localparam int WC  = 2;
`ifdef MEM_RESPONDER_WAIT_EN
  localparam int XL = WC;
`else
  localparam int XL = 0;
`endif
  localparam logic [31:0] LED_A = 32'hFFFF_FFFC;
  localparam logic [31:0] TMR_A = 32'hFFFF_FFF8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] leds;
  logic [31:0] ms_count;
  int n_chk = 0, n_fail = 0, cyc = 0, t0 = 0;
  logic [7:0] m_mem [4*DW];
  logic [7:0] m_leds = 8'h00;
  mem_responder_if bus ();
  mem_responder #(.DEPTH_WORDS(DW), .CLK_PER_MS(CPM), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .leds(leds), .ms_count(ms_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3,
                       output logic [31:0] rd, output logic er, output int lat);
    int sz = 1 << f3[1:0];
    logic mmio, f3_ok;
    mmio  = a == LED_A || a == TMR_A;
    f3_ok = we ? f3 <= 3'd2 : f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    er    = !f3_ok || (a % sz) != 0 || (mmio ? we && sz != 4 : a >= 4 * DW);
    rd    = '0;
    lat   = 1 + XL;
    if (er) return;
    if (a == LED_A) begin
      if (we) m_leds = wd[7:0];
      else rd = {24'h0, m_leds};
    end else if (a == TMR_A) begin
      if (we) t0 = cyc + 1;
      else rd = 32'((cyc - t0) / CPM);
    end else if (we) begin
      for (int k = 0; k < sz; k++) m_mem[a + k] = wd[8*k +: 8];
    end else begin
      lat = 2 + XL;
      for (int k = 0; k < sz; k++) rd[8*k +: 8] = m_mem[a + k];
      if (f3 == 3'd0) rd = {{24{rd[7]}}, rd[7:0]};
      else if (f3 == 3'd1) rd = {{16{rd[15]}}, rd[15:0]};
    end
  endtask
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3, input string tag);
    logic [31:0] erd;
    logic eer;
    int elat, lat;
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd1);
    model(we, a, wd, f3, erd, eer, elat);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = wd; bus.req_funct3 = f3;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_we = 1'($urandom); bus.req_addr = $urandom;
    bus.req_wdata = $urandom; bus.req_funct3 = 3'($urandom);
    lat = 1;
    chk({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
    while (!bus.rsp_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_rdata"}, bus.rsp_rdata, erd);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(eer));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_leds"}, 32'(leds), 32'(m_leds));
    chk({tag, "_ms"}, ms_count, 32'((cyc - t0) / CPM));
  endtask
  initial begin
    logic seen, eer;
    logic [31:0] a, erd;
    logic [2:0] f3;
    int sel, elat;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_funct3 = '0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", 32'(bus.req_ready), 32'd0);
    chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_leds", 32'(leds), 32'd0);
    chk("rst_ms", ms_count, 32'd0);
    rst_n = 1'b1;
    t0 = cyc;
    @(negedge clk);
    for (int i = 0; i < DW; i++) xfer(1'b1, 32'(4 * i), $urandom, 3'd2, "init");
    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, "sw10");
    xfer(1'b0, 32'h10, 32'h0, 3'd2, "lw10");
    xfer(1'b1, 32'h11, 32'h80, 3'd0, "sb11");
    xfer(1'b0, 32'h11, 32'h0, 3'd0, "lb11");
    xfer(1'b0, 32'h11, 32'h0, 3'd4, "lbu11");
    xfer(1'b0, 32'h10, 32'h0, 3'd2, "lw10b");
    xfer(1'b0, 32'h13, 32'h0, 3'd1, "lh13");
    xfer(1'b0, 32'h12, 32'h0, 3'd2, "lw12");
    xfer(1'b1, 32'h12, 32'h55, 3'd2, "sw12");
    xfer(1'b1, 32'h11, 32'h66, 3'd1, "sh11");
    xfer(1'b1, 32'h10, 32'h77, 3'd4, "sbu10");
    xfer(1'b0, 32'h10, 32'h0, 3'd3, "f3_3");
    xfer(1'b0, 32'h10, 32'h0, 3'd2, "lw10c");
    xfer(1'b0, 32'h12, 32'h0, 3'd5, "lhu12");
    xfer(1'b0, 32'(4 * DW), 32'h0, 3'd2, "lw_oor");
    xfer(1'b1, 32'(4 * DW), 32'h1, 3'd2, "sw_oor");
    xfer(1'b0, 32'(4 * DW - 4), 32'h0, 3'd2, "lw_last");
    xfer(1'b1, LED_A, 32'h1A5, 3'd2, "sw_led");
    chk("led_a5", 32'(leds), 32'hA5);
    xfer(1'b1, LED_A, 32'h33, 3'd0, "sb_led");
    chk("led_keep", 32'(leds), 32'hA5);
    xfer(1'b0, LED_A, 32'h0, 3'd2, "lw_led");
    xfer(1'b1, TMR_A, 32'hFFFF, 3'd2, "sw_tmr");
    for (int i = 0; i < 40 && cyc - t0 < 12; i++) @(negedge clk);
    chk("ms_12", ms_count, 32'd3);
    xfer(1'b0, TMR_A, 32'h0, 3'd2, "lw_tmr");
    for (int n = 0; n < 300; n++) begin
      f3  = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a   = sel == 0 ? LED_A : sel == 1 ? TMR_A :
            sel == 2 ? 32'(4 * DW) + 32'($urandom_range(0, 4096)) : 32'($urandom_range(0, 4 * DW - 1));
      if (sel > 2 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << f3[1:0]) - 1);
      xfer(1'($urandom_range(0, 1)), a, $urandom, f3, "rnd");
    end
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h20; bus.req_wdata = '0; bus.req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    t0 = cyc;
    m_leds = 8'h00;
    @(negedge clk);
    chk("rstld_rdy0", 32'(bus.req_ready), 32'd0);
    chk("rstld_vld0", 32'(bus.rsp_valid), 32'd0);
    chk("rstld_leds", 32'(leds), 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= bus.rsp_valid;
    end
    chk("rstld_norsp", 32'(seen), 32'd0);
    chk("rstld_rdy1", 32'(bus.req_ready), 32'd1);
    model(1'b1, 32'h24, 32'h1234_5678, 3'd2, erd, eer, elat);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h24; bus.req_wdata = 32'h1234_5678; bus.req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    t0 = cyc;
    m_leds = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, 32'h24, 32'h0, 3'd2, "rstst_lw");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
